// File: rtl/serial_frame_rx_if.sv
// Output handshake bundle for serial_frame_rx.
//   out_data  : received word
//   out_valid : out_data holds an unconsumed word
//   out_ready : consumer accepts the word this cycle
// master = receiver side (drives data/valid), slave = consumer side.
interface serial_frame_rx_if #(
    parameter int BITS = 5
);
    logic [BITS-1:0] out_data;
    logic            out_valid;
    logic            out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit (0), BITS data bits LSB first, optional
// even-parity bit, stop bit (1), one bit per clk. Good words land in a
// one-word holding buffer presented on a valid/ready port.
//   clk, rstn : clock, asynchronous active-low reset
//   sin       : serial line, idles high
//   rx_out    : out_data / out_valid / out_ready handshake (master side)
//   perr      : one-cycle pulse, frame failed parity
//   ferr      : one-cycle pulse, stop bit sampled 0
//   ovf       : sticky, good word dropped because the buffer was full
//   err_clr   : synchronous clear of ovf
module serial_frame_rx #(
    parameter int BITS      = 5,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                sin,
    input  logic                err_clr,
    output logic                perr,
    output logic                ferr,
    output logic                ovf,
    serial_frame_rx_if.master   rx_out
);
    localparam int            CW   = $clog2(BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DATA, S_PAR, S_STOP, S_BRK
    } st_t;

    st_t             st, nxt;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] shreg;
    logic            pflag;
    logic [BITS-1:0] data_q;
    logic            vld_q;

    logic cnt_clr, cnt_inc, shift_en, par_ld;
    logic done_ok, done_perr, done_ferr;
    logic load, drop, xfer;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st <= S_IDLE;
        else       st <= nxt;
    end

    always_comb begin
        nxt       = st;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        shift_en  = 1'b0;
        par_ld    = 1'b0;
        done_ok   = 1'b0;
        done_perr = 1'b0;
        done_ferr = 1'b0;
        case (st)
            S_IDLE: if (!sin) begin
                nxt     = S_DATA;
                cnt_clr = 1'b1;
            end
            S_DATA: begin
                shift_en = 1'b1;
                if (cnt == LAST) nxt = PARITY_EN ? S_PAR : S_STOP;
                else             cnt_inc = 1'b1;
            end
            S_PAR: begin
                par_ld = 1'b1;
                nxt    = S_STOP;
            end
            S_STOP: begin
                // A bad stop bit wins over a parity error.
                if (sin) begin
                    nxt = S_IDLE;
                    if (pflag) done_perr = 1'b1;
                    else       done_ok   = 1'b1;
                end else begin
                    done_ferr = 1'b1;
                    nxt       = S_BRK;
                end
            end
            // Line must return high before a new start bit is honoured.
            S_BRK: if (sin) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Receive datapath: bit counter, right-shifting deserializer, parity flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= '0;
            shreg <= '0;
            pflag <= 1'b0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            if (shift_en) shreg <= {sin, shreg[BITS-1:1]};
            // pflag stays 0 when there is no parity bit.
            if (cnt_clr)     pflag <= 1'b0;
            else if (par_ld) pflag <= (^shreg) ^ sin;
        end
    end

    // Holding buffer: a drain and a load in the same cycle keep out_valid high.
    assign xfer = vld_q && rx_out.out_ready;
    assign load = done_ok && (!vld_q || rx_out.out_ready);
    assign drop = done_ok && vld_q && !rx_out.out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (load) begin
                data_q <= shreg;
                vld_q  <= 1'b1;
            end else if (xfer) begin
                vld_q  <= 1'b0;
            end
            perr <= done_perr;
            ferr <= done_ferr;
            // New overflow beats a simultaneous clear.
            if (drop)         ovf <= 1'b1;
            else if (err_clr) ovf <= 1'b0;
        end
    end

    assign rx_out.out_data  = data_q;
    assign rx_out.out_valid = vld_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (BITS=5, PARITY_EN=1). Inputs change
// 1 time unit after the rising edge; outputs are checked there too, so each
// check sees the state produced by the edge that just sampled the last bit.
module tb_serial_frame_rx;
    logic clk = 1'b0;
    logic rstn, sin, err_clr;
    logic perr, ferr, ovf;
    int   n_cmp = 0;
    int   n_err = 0;
    int   vld_n = 0, perr_n = 0, ferr_n = 0;
    int   v0, p0, f0;

    serial_frame_rx_if #(.BITS(5)) bus ();

    serial_frame_rx #(.BITS(5), .PARITY_EN(1'b1)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .sin     (sin),
        .err_clr (err_clr),
        .perr    (perr),
        .ferr    (ferr),
        .ovf     (ovf),
        .rx_out  (bus)
    );

    always #5 clk = ~clk;

    // Pulse/valid cycle counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.out_valid) vld_n  = vld_n + 1;
        if (perr)          perr_n = perr_n + 1;
        if (ferr)          ferr_n = ferr_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    // Start, data LSB first, parity (optionally corrupted); stop sent by caller.
    task automatic body(input logic [4:0] d, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(d[i]);
        send_bit((^d) ^ bad_par);
    endtask

    task automatic frame(input logic [4:0] d, input logic bad_par, input logic stop);
        body(d, bad_par);
        send_bit(stop);
    endtask

    logic v1 [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        rstn = 1'b0; sin = 1'b1; err_clr = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data",  bus.out_data,  0);
        chk("rst_perr",  perr, 0);
        chk("rst_ferr",  ferr, 0);
        chk("rst_ovf",   ovf,  0);
        rstn = 1'b1;
        send_bit(1'b1);

        // Single good frame: start at index 2, stop at index 9 -> 22.
        bus.out_ready = 1'b1;
        v0 = vld_n; p0 = perr_n; f0 = ferr_n;
        for (int i = 0; i < 9; i++) send_bit(v1[i]);
        chk("t1_valid_early", bus.out_valid, 0);
        send_bit(v1[9]);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_data",  bus.out_data, 22);
        send_bit(v1[10]);
        chk("t1_valid_drop", bus.out_valid, 0);
        chk("t1_valid_cycles", vld_n - v0, 1);
        chk("t1_perr_cnt", perr_n - p0, 0);
        chk("t1_ferr_cnt", ferr_n - f0, 0);
        chk("t1_ovf", ovf, 0);

        // Parity error.
        v0 = vld_n; p0 = perr_n;
        frame(5'd22, 1'b1, 1'b1);
        chk("t2_perr", perr, 1);
        chk("t2_valid", bus.out_valid, 0);
        send_bit(1'b1);
        chk("t2_perr_end", perr, 0);
        chk("t2_perr_cnt", perr_n - p0, 1);
        chk("t2_valid_cycles", vld_n - v0, 0);

        // Framing error, 4-cycle break, then a good frame carrying 3.
        v0 = vld_n; f0 = ferr_n;
        frame(5'd22, 1'b0, 1'b0);
        chk("t3_ferr", ferr, 1);
        chk("t3_valid", bus.out_valid, 0);
        repeat (4) send_bit(1'b0);
        send_bit(1'b1);
        chk("t3_ferr_cnt", ferr_n - f0, 1);
        chk("t3_valid_cycles", vld_n - v0, 0);
        frame(5'd3, 1'b0, 1'b1);
        chk("t3_valid_good", bus.out_valid, 1);
        chk("t3_data_good",  bus.out_data, 3);
        send_bit(1'b1);

        // Overflow with two back-to-back frames.
        bus.out_ready = 1'b0;
        frame(5'd1, 1'b0, 1'b1);
        chk("t4_data1", bus.out_data, 1);
        chk("t4_ovf0", ovf, 0);
        frame(5'd2, 1'b0, 1'b1);
        chk("t4_valid", bus.out_valid, 1);
        chk("t4_data_held", bus.out_data, 1);
        chk("t4_ovf1", ovf, 1);
        bus.out_ready = 1'b1;
        send_bit(1'b1);
        bus.out_ready = 1'b0;
        chk("t4_drained", bus.out_valid, 0);
        chk("t4_ovf_sticky", ovf, 1);
        err_clr = 1'b1;
        send_bit(1'b1);
        err_clr = 1'b0;
        chk("t4_ovf_clr", ovf, 0);

        // Drain and load in the same cycle.
        frame(5'd7, 1'b0, 1'b1);
        chk("t5_data7", bus.out_data, 7);
        body(5'd9, 1'b0);
        chk("t5_data7_held", bus.out_data, 7);
        bus.out_ready = 1'b1;
        send_bit(1'b1);
        bus.out_ready = 1'b0;
        chk("t5_valid", bus.out_valid, 1);
        chk("t5_data9", bus.out_data, 9);
        chk("t5_ovf", ovf, 0);
        bus.out_ready = 1'b1;
        send_bit(1'b1);
        chk("t5_drained", bus.out_valid, 0);

        // Reset mid-frame with a held word and ovf set.
        bus.out_ready = 1'b0;
        frame(5'd5, 1'b0, 1'b1);
        frame(5'd6, 1'b0, 1'b1);
        chk("t6_pre_ovf", ovf, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_data",  bus.out_data, 0);
        chk("t6_rst_ovf",   ovf, 0);
        chk("t6_rst_perr",  perr, 0);
        chk("t6_rst_ferr",  ferr, 0);
        sin = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        chk("t6_idle_valid", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        frame(5'd31, 1'b0, 1'b1);
        chk("t6_valid31", bus.out_valid, 1);
        chk("t6_data31",  bus.out_data, 31);
        send_bit(1'b1);
        chk("t6_drained", bus.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Framed serial receiver. It deserializes a 1-bit line, one bit per `clk`, into `BITS`-wide words and presents each word on a valid/ready output port. Each frame carries a start bit, LSB-first data, an optional even-parity bit and a stop bit. It is the receive end for the counter-serializer path: it replaces the free-running SIPO with frame alignment, error detection and a one-word holding buffer.

## Interface
- `BITS`, default 5: data bits per frame (≥ 2).
- `PARITY_EN`, default 1: 1 = an even-parity bit follows the data; 0 = no parity bit.
- `clk` input, 1 bit: single clock; all logic on its rising edge.
- `rstn` input, 1 bit: reset, asynchronous and active-low.
- `sin` input, 1 bit: serial line, sampled once per `clk`; idles high.
- `out_data` output, `BITS` bits: received word.
- `out_valid` output, 1 bit: `out_data` holds an unconsumed word.
- `out_ready` input, 1 bit: consumer accepts the word; a transfer occurs when `out_valid && out_ready`.
- `perr` output, 1 bit: one-cycle pulse when a frame fails the parity check.
- `ferr` output, 1 bit: one-cycle pulse when a frame's stop bit samples 0.
- `ovf` output, 1 bit: sticky; a good frame was dropped because the buffer was full.
- `err_clr` input, 1 bit: synchronous clear of `ovf`.

## Operation
- Frame layout on `sin`, one bit per cycle:
  - start bit: 0;
  - `BITS` data bits, LSB first;
  - parity bit, only if `PARITY_EN`: XOR of the data bits, so the total count of ones is even;
  - stop bit: 1.
- FSM states and transitions:
  - IDLE: on `sin == 0`, go to DATA and clear the bit counter; otherwise stay.
  - DATA: shift `sin` into the MSB of the shift register (right shift). After `BITS` bits, go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: latch the parity-mismatch flag, then go to STOP.
  - STOP:
    - `sin == 1`: frame complete, go to IDLE.
    - `sin == 0`: pulse `ferr`, drop the word, go to BREAK.
  - BREAK: wait for `sin == 1`, then go to IDLE. A low line is never taken as a new start bit from this state.
- Bit counter width is `$clog2(BITS+1)`. It counts 0..`BITS-1` and is cleared on entry to DATA.
- Frame completion (stop bit = 1):
  - Parity mismatch: pulse `perr` and drop the word. `out_valid` and `out_data` are unchanged.
  - Parity good, buffer empty or being drained this cycle (`out_valid && out_ready`): load `out_data` and set `out_valid`.
  - Parity good, `out_valid && !out_ready`: drop the new word, keep the old one, set `ovf`.
- A word with both parity and stop errors pulses only `ferr`.
- `ovf` clears only on `err_clr` or reset. If `err_clr` and a new overflow occur in the same cycle, `ovf` ends at 1.
- `out_valid` clears on a transfer unless a new word loads in the same cycle.

## Timing
- Reset values:
  - `out_data` = 0, `out_valid` = 0, `perr` = 0, `ferr` = 0, `ovf` = 0;
  - FSM = IDLE, shift register = 0, bit counter = 0.
- Reset asserted mid-frame aborts the frame immediately. After release the FSM is in IDLE and the partial frame is discarded.
- Let cycle 0 be the cycle the start bit is sampled. Then:
  - data bits are sampled in cycles 1..`BITS`;
  - parity is sampled in cycle `BITS+1` (if `PARITY_EN`);
  - stop is sampled in cycle `BITS+1+PARITY_EN`.
- `out_valid`, `perr`, `ferr` and `ovf` update at the edge ending the stop cycle, i.e. they are visible the following cycle. Latency from start bit to `out_valid` is `BITS+2+PARITY_EN` cycles.
- Back-to-back frames are supported: a start bit in the cycle right after a good stop bit is accepted. Frame period is `BITS+2+PARITY_EN` cycles.
- `out_data` is stable while `out_valid && !out_ready`.
- `out_ready` has no combinational path to any output.

## Test plan
- Single good frame: `BITS`=5, `PARITY_EN`=1, `out_ready`=1, `sin` = 1,1,0,0,1,1,0,1,1,1,1.
  - Required: `out_data` = 5'd22, with `out_valid` high exactly one cycle, 8 cycles after the start bit.
  - Required: `perr`, `ferr` and `ovf` stay 0.
- Parity error: same frame with the parity bit driven 0.
  - Required: `perr` pulses once, 1 cycle after the stop bit; `out_valid` stays 0.
- Framing error and break: same frame with stop = 0, then `sin` held 0 for 4 cycles, then high, then a good frame carrying 5'd3.
  - Required: `ferr` pulses once and no word is emitted for the broken frame.
  - Required: 5'd3 is received correctly afterwards.
- Overflow: `out_ready`=0, two back-to-back good frames carrying 5'd1 then 5'd2.
  - Required: `out_data` stays 5'd1 and `ovf` = 1 after the second stop bit.
  - Then pulse `out_ready` for one cycle: `out_valid` → 0. Then pulse `err_clr`: `ovf` → 0.
- Drain and load in the same cycle: `out_valid` = 1 with 5'd7, and `out_ready` = 1 in the same cycle as a good stop bit for 5'd9.
  - Required: `out_valid` stays 1, `out_data` = 5'd9, `ovf` = 0.
- Reset mid-frame: pull `rstn` low after 3 data bits, then release, then send a good 5'd31 frame.
  - Required: all outputs read 0 after reset, and 5'd31 is received correctly.
